seq_magnitude_comparator: RTL

- Parametrised, multi-cycle magnitude comparator; the next generation of the team's 4-bit combinational comparator.
- Compares two WIDTH-bit operands, unsigned or two's-complement, scanning DIGIT bits per clock MSB-first behind a start/done handshake.
- Optional early termination at the first differing digit.
- Used where wide compares would break timing in a single cycle: sort/threshold units and min/max trackers.

---
 rtl/seq_magnitude_comparator.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator, DIGIT bits per clock, MSB-first.
// Optional macro CMP_EARLY_EXIT_EN ends the scan at the first differing digit.
module seq_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                signed_mode,
    input  logic [WIDTH-1:0]                    a,
    input  logic [WIDTH-1:0]                    b,
    output logic                                busy,
    output logic                                done,
    output logic                                a_eq_b,
    output logic                                a_lt_b,
    output logic                                a_gt_b,
    output logic [$clog2(WIDTH/DIGIT+1)-1:0]    steps
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d, sb_q, sb_d;
    logic               gt_q, gt_d, lt_q, lt_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               eq_o_q, eq_o_d, lt_o_q, lt_o_d, gt_o_q, gt_o_d;
    logic [CW-1:0]      steps_q, steps_d;

    logic [DIGIT-1:0]   dig_a, dig_b;
    logic               diff, gt_n, lt_n, last, fin;

    // Flipping the sign bit maps two's-complement onto offset binary,
    // so the scan itself is always unsigned.
    logic [WIDTH-1:0]   sign_flip;
    assign sign_flip = {signed_mode, {(WIDTH-1){1'b0}}};

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        eq_o_d  = eq_o_q;
        lt_o_d  = lt_o_q;
        gt_o_d  = gt_o_q;
        steps_d = steps_q;

        dig_a = sa_q[WIDTH-1 -: DIGIT];
        dig_b = sb_q[WIDTH-1 -: DIGIT];
        diff  = !(gt_q || lt_q) && (dig_a != dig_b);
        gt_n  = diff ? (dig_a > dig_b)  : gt_q;
        lt_n  = diff ? !(dig_a > dig_b) : lt_q;
        last  = (cnt_q == CW'(NDIG - 1));
`ifdef CMP_EARLY_EXIT_EN
        fin   = last || diff;
`else
        fin   = last;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d    = a ^ sign_flip;
                    sb_d    = b ^ sign_flip;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                sa_d  = sa_q << DIGIT;
                sb_d  = sb_q << DIGIT;
                gt_d  = gt_n;
                lt_d  = lt_n;
                cnt_d = cnt_q + CW'(1);
                if (fin) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    eq_o_d  = !(gt_n || lt_n);
                    lt_o_d  = lt_n;
                    gt_o_d  = gt_n;
                    steps_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_o_q  <= 1'b0;
            lt_o_q  <= 1'b0;
            gt_o_q  <= 1'b0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            eq_o_q  <= eq_o_d;
            lt_o_q  <= lt_o_d;
            gt_o_q  <= gt_o_d;
            steps_q <= steps_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign a_eq_b = eq_o_q;
    assign a_lt_b = lt_o_q;
    assign a_gt_b = gt_o_q;
    assign steps  = steps_q;
endmodule
